// File: rtl/image_filter_pkg.sv
// image_filter_pkg: shared pixel type, gate FSM states and default frame geometry.
// Contents: rgb_t 24-bit {R,G,B} pixel, state_t {WAIT_SOF, ACTIVE},
// default FRAME_W/FRAME_H/CW values used by roi_pixel_gate.
package image_filter_pkg;
    typedef logic [23:0] rgb_t;
    typedef enum logic {WAIT_SOF, ACTIVE} state_t;
    localparam int FRAME_W_DEF = 640;
    localparam int FRAME_H_DEF = 480;
    localparam int CW_DEF      = 11;
endpackage

// File: rtl/roi_pixel_gate_if.sv
// roi_pixel_gate_if: AXI4-Stream video bus (tuser=SOF, tlast=EOL).
// Signals: tdata (rgb_t), tvalid, tready, tuser, tlast.
// Modports: master drives the stream, slave consumes it and drives tready.
interface roi_pixel_gate_if;
    import image_filter_pkg::*;
    rgb_t tdata;
    logic tvalid;
    logic tready;
    logic tuser;
    logic tlast;
    modport master (output tdata, tvalid, tuser, tlast, input tready);
    modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/roi_pos_counter.sv
// roi_pos_counter: column/row tracker for the ROI pixel gate.
// Ports: clk, resetn (sync, active-low); take_i = beat belongs to a live frame,
// sof_i/eol_i = tuser/tlast of that beat; x_o/y_o = position of the current beat,
// eof_o = last beat of the last line, len_err_o = line ended at the wrong column.
module roi_pos_counter #(
    parameter int FRAME_W = 640,
    parameter int FRAME_H = 480,
    parameter int CW      = 11
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          take_i,
    input  logic          sof_i,
    input  logic          eol_i,
    output logic [CW-1:0] x_o,
    output logic [CW-1:0] y_o,
    output logic          eof_o,
    output logic          len_err_o
);
    localparam logic [CW-1:0] XMAX = CW'(FRAME_W - 1);
    localparam logic [CW-1:0] YMAX = CW'(FRAME_H - 1);
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    // An SOF beat is always position (0,0), whatever the counters held.
    assign x_o       = sof_i ? '0 : x_q;
    assign y_o       = sof_i ? '0 : y_q;
    assign eof_o     = take_i & eol_i & (y_o == YMAX);
    assign len_err_o = take_i & eol_i & (x_o != XMAX);
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (take_i) begin
            // Overlong lines keep reusing the last column.
            x_d = eol_i ? '0 : (x_o == XMAX ? XMAX : x_o + 1'b1);
            y_d = eol_i ? (eof_o ? '0 : y_o + 1'b1) : y_o;
        end
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end
endmodule

// File: rtl/roi_pixel_gate.sv
// roi_pixel_gate: forwards pixels inside a rectangular ROI of a live frame, with
// frame_start/frame_done pulses for re-arming and sampling a downstream min filter.
// Ports: clk, resetn (sync, active-low); s_axis (slave AXIS video, never stalls);
// roi_x0/x1/y0/y1 inclusive bounds, latched on each SOF; pixel_out/valid_out gated
// pixel; frame_start, frame_done, err_line single-cycle pulses. All outputs registered.
// Option ROI_PIXCOUNT_EN: adds roi_count = valid_out beats of the last completed frame.
module roi_pixel_gate
    import image_filter_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int FRAME_H = FRAME_H_DEF,
    parameter int CW      = CW_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    roi_pixel_gate_if.slave    s_axis,
    input  logic [CW-1:0]      roi_x0,
    input  logic [CW-1:0]      roi_x1,
    input  logic [CW-1:0]      roi_y0,
    input  logic [CW-1:0]      roi_y1,
    output rgb_t               pixel_out,
    output logic               valid_out,
    output logic               frame_start,
    output logic               frame_done,
    output logic               err_line
`ifdef ROI_PIXCOUNT_EN
    ,output logic [2*CW-1:0]   roi_count
`endif
);
    state_t state_q, state_d;
    logic [4*CW-1:0] roi_q, roi_d, roi_in, roi_b;
    rgb_t pixel_q, pixel_d;
    logic valid_q, valid_d, fs_q, fs_d, fd_q, fd_d, err_q, err_d;
    logic beat, take, in_roi, eof, len_err;
    logic [CW-1:0] x, y;
    assign s_axis.tready = 1'b1;
    assign beat   = s_axis.tvalid;
    // Beats outside a frame are dropped unless they open one.
    assign take   = beat & (state_q == ACTIVE | s_axis.tuser);
    assign roi_in = {roi_x0, roi_x1, roi_y0, roi_y1};
    // The SOF beat must already see the ROI it is latching.
    assign roi_b  = s_axis.tuser ? roi_in : roi_q;
    assign in_roi = (x >= roi_b[4*CW-1 -: CW]) && (x <= roi_b[3*CW-1 -: CW]) &&
                    (y >= roi_b[2*CW-1 -: CW]) && (y <= roi_b[CW-1 -: CW]);
    roi_pos_counter #(.FRAME_W(FRAME_W), .FRAME_H(FRAME_H), .CW(CW)) u_pos (
        .clk       (clk),
        .resetn    (resetn),
        .take_i    (take),
        .sof_i     (s_axis.tuser),
        .eol_i     (s_axis.tlast),
        .x_o       (x),
        .y_o       (y),
        .eof_o     (eof),
        .len_err_o (len_err)
    );
    always_comb begin
        state_d = take ? (eof ? WAIT_SOF : ACTIVE) : state_q;
        roi_d   = (take & s_axis.tuser) ? roi_in : roi_q;
        pixel_d = take ? s_axis.tdata : pixel_q;
        valid_d = take & in_roi;
        fs_d    = take & s_axis.tuser;
        fd_d    = eof;
        // SOF inside a live frame aborts it; reported once even if the line was also short.
        err_d   = len_err | (beat & s_axis.tuser & state_q == ACTIVE);
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= WAIT_SOF;
            roi_q   <= '0;
            pixel_q <= '0;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            fd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            roi_q   <= roi_d;
            pixel_q <= pixel_d;
            valid_q <= valid_d;
            fs_q    <= fs_d;
            fd_q    <= fd_d;
            err_q   <= err_d;
        end
    end
    assign pixel_out   = pixel_q;
    assign valid_out   = valid_q;
    assign frame_start = fs_q;
    assign frame_done  = fd_q;
    assign err_line    = err_q;
`ifdef ROI_PIXCOUNT_EN
    logic [2*CW-1:0] cnt_q, cnt_d, cnt_next, rc_q, rc_d;
    // Running count restarts on every SOF so aborted frames never leak into the total.
    always_comb begin
        cnt_next = (s_axis.tuser ? '0 : cnt_q) + (2*CW)'(in_roi);
        cnt_d    = take ? cnt_next : cnt_q;
        rc_d     = eof ? cnt_next : rc_q;
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
            rc_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            rc_q  <= rc_d;
        end
    end
    assign roi_count = rc_q;
`endif
endmodule

// File: tb/tb_roi_pixel_gate.sv
// tb_roi_pixel_gate: directed frames against a beat-level model of the ROI gate.
module tb_roi_pixel_gate;
    import image_filter_pkg::*;
    localparam int W = 8, H = 4, CW = 11;
    logic clk = 1'b0, resetn = 1'b0;
    always #5 clk = ~clk;
    roi_pixel_gate_if bus();
    logic [CW-1:0] roi_x0 = 2, roi_x1 = 5, roi_y0 = 1, roi_y1 = 2;
    rgb_t pixel_out;
    logic valid_out, frame_start, frame_done, err_line;
`ifdef ROI_PIXCOUNT_EN
    logic [2*CW-1:0] roi_count;
`endif
    roi_pixel_gate #(.FRAME_W(W), .FRAME_H(H), .CW(CW)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .s_axis      (bus.slave),
        .roi_x0      (roi_x0),
        .roi_x1      (roi_x1),
        .roi_y0      (roi_y0),
        .roi_y1      (roi_y1),
        .pixel_out   (pixel_out),
        .valid_out   (valid_out),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .err_line    (err_line)
`ifdef ROI_PIXCOUNT_EN
        ,.roi_count  (roi_count)
`endif
    );
    int total = 0, bad = 0;
    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask
    // Beat-level model: walks each accepted beat through the frame rules in plain integers.
    int live = 0, mx = 0, my = 0, sx0 = 0, sx1 = 0, sy0 = 0, sy1 = 0, cnt = 0, beat_no = 0;
    int e_pix = 0, e_val = 0, e_fs = 0, e_fd = 0, e_err = 0, e_cnt = 0;
    always @(posedge clk) begin
        if (!resetn) begin
            live = 0; mx = 0; my = 0; sx0 = 0; sx1 = 0; sy0 = 0; sy1 = 0; cnt = 0;
            e_pix = 0; e_val = 0; e_fs = 0; e_fd = 0; e_err = 0; e_cnt = 0;
        end else begin
            e_val = 0; e_fs = 0; e_fd = 0; e_err = 0;
            if (bus.tvalid) begin
                beat_no++;
                if (bus.tuser) begin
                    if (live != 0) e_err = 1;
                    live = 1; mx = 0; my = 0; cnt = 0; e_fs = 1;
                    sx0 = int'(roi_x0); sx1 = int'(roi_x1); sy0 = int'(roi_y0); sy1 = int'(roi_y1);
                end
                if (live != 0) begin
                    e_pix = int'(bus.tdata);
                    e_val = (mx >= sx0 && mx <= sx1 && my >= sy0 && my <= sy1) ? 1 : 0;
                    cnt += e_val;
                    if (bus.tlast) begin
                        if (mx != W - 1) e_err = 1;
                        if (my == H - 1) begin
                            e_fd = 1; live = 0; e_cnt = cnt;
                        end
                        my++; mx = 0;
                    end else if (mx < W - 1) mx++;
                end
            end
        end
    end
    int n_valid = 0, n_fs = 0, n_fd = 0, n_err = 0, fd_at = 0, fs_at = 0;
    rgb_t vq[$];
    rgb_t q1[$];
    always @(posedge clk) begin
        #1;
        chk("pixel_out", 64'(pixel_out), 64'(e_pix));
        chk("valid_out", 64'(valid_out), 64'(e_val));
        chk("frame_start", 64'(frame_start), 64'(e_fs));
        chk("frame_done", 64'(frame_done), 64'(e_fd));
        chk("err_line", 64'(err_line), 64'(e_err));
`ifdef ROI_PIXCOUNT_EN
        chk("roi_count", 64'(roi_count), 64'(e_cnt));
`endif
        if (valid_out) begin n_valid++; vq.push_back(pixel_out); end
        if (frame_start) begin n_fs++; fs_at = beat_no; end
        if (frame_done) begin n_fd++; fd_at = beat_no; end
        if (err_line) n_err++;
    end
    task automatic drive(input logic v, input logic u, input logic l, input rgb_t d);
        @(negedge clk);
        bus.tvalid = v; bus.tuser = u; bus.tlast = l; bus.tdata = d;
    endtask
    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, '0);
    endtask
    task automatic line(input int tag, input int y, input int len, input bit sof, input bit eol, input int gap);
        for (int x = 0; x < len; x++) begin
            if (gap > 0) idle($urandom_range(gap, 0));
            drive(1'b1, sof && x == 0, eol && x == len - 1, {8'(tag), 8'(y), 8'(x)});
        end
    endtask
    task automatic frame(input int tag, input int gap, input int len1);
        for (int y = 0; y < H; y++) line(tag, y, y == 1 ? len1 : W, y == 0, 1'b1, gap);
    endtask
    task automatic clr();
        @(negedge clk);
        n_valid = 0; n_fs = 0; n_fd = 0; n_err = 0; fd_at = 0; fs_at = 0; beat_no = 0;
        vq.delete();
    endtask
    initial begin
        bus.tvalid = 1'b0; bus.tuser = 1'b0; bus.tlast = 1'b0; bus.tdata = '0;
        repeat (2) @(negedge clk);
        chk("tready_in_reset", 64'(bus.tready), 64'd1);
        chk("reset_valid", 64'(valid_out), 64'd0);
        resetn = 1'b1;
        // Gapless frame, ROI columns 2..5 rows 1..2.
        clr(); frame(1, 0, W); idle(3);
        chk("t1_valid_count", 64'(n_valid), 64'd8);
        chk("t1_fs_count", 64'(n_fs), 64'd1);
        chk("t1_fs_beat", 64'(fs_at), 64'd1);
        chk("t1_fd_beat", 64'(fd_at), 64'd32);
        chk("t1_err_count", 64'(n_err), 64'd0);
        chk("t1_first_pix", 64'(vq.size() > 0 ? vq[0] : '0), 64'h010102);
        chk("t1_bus_tready", 64'(bus.tready), 64'd1);
`ifdef ROI_PIXCOUNT_EN
        chk("t1_roi_count", 64'(roi_count), 64'd8);
`endif
        q1 = vq;
        // Same frame with random idle gaps must gate the same pixels.
        clr(); frame(1, 3, W); idle(3);
        chk("t2_valid_count", 64'(n_valid), 64'd8);
        chk("t2_fd_count", 64'(n_fd), 64'd1);
        for (int i = 0; i < 8; i++) chk("t2_pix_match", 64'(i < vq.size() ? vq[i] : '0), 64'(q1[i]));
        // Short line 1 (6 beats).
        clr(); frame(2, 0, 6); idle(3);
        chk("t3_err_count", 64'(n_err), 64'd1);
        chk("t3_fd_count", 64'(n_fd), 64'd1);
        chk("t3_fd_beat", 64'(fd_at), 64'd30);
        chk("t3_valid_count", 64'(n_valid), 64'd8);
        // SOF at line 2 beat 3 aborts and restarts.
        clr(); line(3, 0, W, 1'b1, 1'b1, 0); line(3, 1, W, 1'b0, 1'b1, 0); line(3, 2, 2, 1'b0, 1'b0, 0);
        frame(4, 0, W); idle(3);
        chk("t4_err_count", 64'(n_err), 64'd1);
        chk("t4_fs_count", 64'(n_fs), 64'd2);
        chk("t4_fd_count", 64'(n_fd), 64'd1);
        chk("t4_fd_beat", 64'(fd_at), 64'd50);
        chk("t4_valid_count", 64'(n_valid), 64'd12);
        // Inverted ROI columns: empty region.
        @(negedge clk); roi_x0 = 5; roi_x1 = 2;
        clr(); frame(5, 0, W); idle(3);
        chk("t5_valid_count", 64'(n_valid), 64'd0);
        chk("t5_fd_count", 64'(n_fd), 64'd1);
`ifdef ROI_PIXCOUNT_EN
        chk("t5_roi_count", 64'(roi_count), 64'd0);
`endif
        @(negedge clk); roi_x0 = 2; roi_x1 = 5;
        // Reset mid-line, then beats without SOF are dropped.
        clr(); line(6, 0, W, 1'b1, 1'b1, 0); line(6, 1, 4, 1'b0, 1'b0, 0);
        @(negedge clk); resetn = 1'b0; bus.tvalid = 1'b1; bus.tuser = 1'b0; bus.tlast = 1'b0; bus.tdata = 24'h060104;
        @(negedge clk); resetn = 1'b1;
        chk("t6_reset_pix", 64'(pixel_out), 64'd0);
        chk("t6_reset_valid", 64'(valid_out), 64'd0);
        clr(); line(6, 1, 5, 1'b0, 1'b0, 0); idle(2);
        chk("t6_drop_valid", 64'(n_valid), 64'd0);
        chk("t6_drop_fs", 64'(n_fs), 64'd0);
        chk("t6_drop_pix", 64'(pixel_out), 64'd0);
        clr(); frame(7, 0, W); idle(3);
        chk("t6_valid_count", 64'(n_valid), 64'd8);
        chk("t6_fd_count", 64'(n_fd), 64'd1);
        chk("t6_err_count", 64'(n_err), 64'd0);
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
